// File: rtl/mips_pkg.sv
// ISA opcode encodings, controller states and decoded-opcode class shared by the
// multi-cycle MIPS32 sequencer and its opcode decoder.
package mips_pkg;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_J     = 6'b001111;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_e;

   localparam logic [1:0] PC_SEQ = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_JMP = 2'd2;

   // br_ne distinguishes BNEQZ from BEQZ inside the branch class.
   typedef struct packed {
      logic is_rr;
      logic is_imm;
      logic is_lw;
      logic is_sw;
      logic is_br;
      logic br_ne;
      logic is_jmp;
      logic is_hlt;
      logic is_ill;
   } op_class_t;

endpackage

// File: rtl/mips_op_decode.sv
// Combinational opcode classifier: maps IR[31:26] onto one instruction class,
// with every encoding outside the ISA reported as illegal.
module mips_op_decode
   import mips_pkg::*;
(
   input  logic [5:0] opcode_i,
   output op_class_t  cls_o
);

   always_comb begin
      cls_o = '0;
      case (opcode_i)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: cls_o.is_rr  = 1'b1;
         OP_ADDI, OP_SUBI, OP_SLTI:                     cls_o.is_imm = 1'b1;
         OP_LW:    cls_o.is_lw  = 1'b1;
         OP_SW:    cls_o.is_sw  = 1'b1;
         OP_BEQZ:  cls_o.is_br  = 1'b1;
         OP_BNEQZ: begin
            cls_o.is_br = 1'b1;
            cls_o.br_ne = 1'b1;
         end
         OP_J:     cls_o.is_jmp = 1'b1;
         OP_HLT:   cls_o.is_hlt = 1'b1;
         default:  cls_o.is_ill = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the MIPS32 datapath: drives mux selects
// and write strobes, bounds memory waits, halts on HLT or bus timeout, counts retires.
module mc_ctrl_fsm
   import mips_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      ir_q,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             eqz,
   output logic             imem_rd,
   output logic             ir_wr,
   output logic             pc_wr,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic             alu_src_b,
   output logic             dmem_rd,
   output logic             dmem_wr,
   output logic             reg_wr,
   output logic             wb_sel,
   output logic [4:0]       rd,
   output logic [2:0]       state_o,
   output logic             halted,
   output logic             bus_err,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam int              WT_W      = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WT_W-1:0] WAIT_LAST = WT_W'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [WT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic             bus_err_q, bus_err_d;
   logic [CNT_W-1:0] instr_cnt_q;
   op_class_t        cls;
   logic             timeout, retire;
   logic             imem_rd_c, ir_wr_c, pc_wr_c, dmem_rd_c, dmem_wr_c, reg_wr_c, ill_c;
   logic             unused_ir;

   mips_op_decode u_dec (
      .opcode_i (ir_q[31:26]),
      .cls_o    (cls)
   );

   // The current cycle is the MEM_TIMEOUT-th request cycle; ready still wins here.
   assign timeout = (wait_cnt_q == WAIT_LAST);

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      bus_err_d  = bus_err_q;
      imem_rd_c  = 1'b0;
      ir_wr_c    = 1'b0;
      pc_wr_c    = 1'b0;
      dmem_rd_c  = 1'b0;
      dmem_wr_c  = 1'b0;
      reg_wr_c   = 1'b0;
      ill_c      = 1'b0;
      pc_src     = PC_SEQ;
      alu_src_a  = 1'b1;
      alu_src_b  = 1'b0;
      case (state_q)
         S_IF: begin
            imem_rd_c = 1'b1;
            if (imem_ready) begin
               ir_wr_c = 1'b1;
               pc_wr_c = 1'b1;
               state_d = S_ID;
            end else if (timeout) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_ID: begin
            if (cls.is_hlt) begin
               state_d = S_HALT;
            end else if (cls.is_jmp) begin
               pc_wr_c = 1'b1;
               pc_src  = PC_JMP;
               state_d = S_IF;
            end else begin
               state_d = S_EX;
            end
         end
         S_EX: begin
            if (cls.is_br) begin
               alu_src_a = 1'b0;
               alu_src_b = 1'b1;
               pc_src    = PC_BR;
               pc_wr_c   = cls.br_ne ? ~eqz : eqz;
               state_d   = S_IF;
            end else if (cls.is_lw || cls.is_sw) begin
               alu_src_b = 1'b1;
               state_d   = S_MEM;
            end else if (cls.is_imm) begin
               alu_src_b = 1'b1;
               state_d   = S_WB;
            end else if (cls.is_rr) begin
               state_d = S_WB;
            end else begin
               ill_c   = 1'b1;
               state_d = S_IF;
            end
         end
         S_MEM: begin
            dmem_rd_c = cls.is_lw;
            dmem_wr_c = cls.is_sw;
            if (dmem_ready) begin
               state_d = cls.is_lw ? S_WB : S_IF;
            end else if (timeout) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_WB: begin
            reg_wr_c = 1'b1;
            state_d  = S_IF;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IF;
      endcase

      // Any state change restarts the wait count, so each IF/MEM visit starts at zero.
      if (state_d != state_q) begin
         wait_cnt_d = '0;
      end else if (state_q == S_IF || state_q == S_MEM) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   assign retire = (state_q != S_IF) && (state_d == S_IF);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IF;
         wait_cnt_q  <= '0;
         bus_err_q   <= 1'b0;
         instr_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         bus_err_q  <= bus_err_d;
         if (retire) begin
            instr_cnt_q <= instr_cnt_q + 1'b1;
         end
      end
   end

   assign imem_rd    = imem_rd_c & rst_n;
   assign ir_wr      = ir_wr_c & rst_n;
   assign pc_wr      = pc_wr_c & rst_n;
   assign dmem_rd    = dmem_rd_c & rst_n;
   assign dmem_wr    = dmem_wr_c & rst_n;
   assign reg_wr     = reg_wr_c & rst_n;
   assign illegal_op = ill_c & rst_n;

   assign rd        = cls.is_rr ? ir_q[15:11] : ir_q[20:16];
   assign wb_sel    = ~cls.is_lw;
   assign state_o   = state_q;
   assign halted    = (state_q == S_HALT);
   assign bus_err   = bus_err_q;
   assign instr_cnt = instr_cnt_q;
   assign unused_ir = ^{ir_q[25:21], ir_q[10:0]};

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction expected cycle traces built from the ISA
// timing rules, driven from directed tables, corner sequences and random programs.
module tb_mc_ctrl_fsm;

   localparam int TO = 4;
   localparam int CW = 4;

   localparam logic [5:0] T_ADD = 6'b000000, T_SUB = 6'b000001, T_AND = 6'b000010;
   localparam logic [5:0] T_OR = 6'b000011, T_SLT = 6'b000100, T_MUL = 6'b000101;
   localparam logic [5:0] T_LW = 6'b001000, T_SW = 6'b001001, T_ADDI = 6'b001010;
   localparam logic [5:0] T_SUBI = 6'b001011, T_SLTI = 6'b001100, T_BNEQZ = 6'b001101;
   localparam logic [5:0] T_BEQZ = 6'b001110, T_J = 6'b001111, T_HLT = 6'b111111;
   localparam logic [5:0] T_BAD = 6'b010000;

   localparam int K_RR = 0, K_IMM = 1, K_LW = 2, K_SW = 3, K_BEQZ = 4;
   localparam int K_BNEZ = 5, K_J = 6, K_HLT = 7, K_ILL = 8;

   typedef struct packed {
      logic [2:0]    st;
      logic          imem_rd;
      logic          ir_wr;
      logic          pc_wr;
      logic          dmem_rd;
      logic          dmem_wr;
      logic          reg_wr;
      logic          ill;
      logic          halted;
      logic          bus_err;
      logic [CW-1:0] cnt;
      logic [1:0]    pc_src;
      logic          src_a;
      logic          src_b;
      logic          wb_sel;
      logic [4:0]    rd;
   } obs_t;

   typedef struct packed {
      logic [31:0] ir;
      logic        irdy;
      logic        drdy;
      logic        ez;
      obs_t        exp;
      obs_t        msk;
   } vec_t;

   typedef struct {
      logic [31:0] word;
      int          iw;
      int          dw;
      bit          ez;
      int          lat;
   } dir_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   ir_q = '0;
   logic          imem_ready = 1'b0, dmem_ready = 1'b0, eqz = 1'b0;
   logic          imem_rd, ir_wr, pc_wr, dmem_rd, dmem_wr, reg_wr, wb_sel;
   logic          alu_src_a, alu_src_b, halted, bus_err, illegal_op;
   logic [1:0]    pc_src;
   logic [4:0]    rd;
   logic [2:0]    state_o;
   logic [CW-1:0] instr_cnt;

   int          tests = 0;
   int          failed = 0;
   int          retired = 0;
   bit          mdl_halt = 1'b0, mdl_berr = 1'b0;
   logic [31:0] mdl_ir = '0;
   vec_t        vq[$];
   dir_t        dt[16];
   logic [5:0]  ops[16];

   mc_ctrl_fsm #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ir_q       (ir_q),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .eqz        (eqz),
      .imem_rd    (imem_rd),
      .ir_wr      (ir_wr),
      .pc_wr      (pc_wr),
      .pc_src     (pc_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .dmem_rd    (dmem_rd),
      .dmem_wr    (dmem_wr),
      .reg_wr     (reg_wr),
      .wb_sel     (wb_sel),
      .rd         (rd),
      .state_o    (state_o),
      .halted     (halted),
      .bus_err    (bus_err),
      .illegal_op (illegal_op),
      .instr_cnt  (instr_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, failed);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int kind(logic [5:0] op);
      case (op)
         T_ADD, T_SUB, T_AND, T_OR, T_SLT, T_MUL: return K_RR;
         T_ADDI, T_SUBI, T_SLTI: return K_IMM;
         T_LW:    return K_LW;
         T_SW:    return K_SW;
         T_BEQZ:  return K_BEQZ;
         T_BNEQZ: return K_BNEZ;
         T_J:     return K_J;
         T_HLT:   return K_HLT;
         default: return K_ILL;
      endcase
   endfunction

   function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                      logic [15:0] lo);
      return {op, rs, rt, lo};
   endfunction

   function automatic obs_t core_mask();
      obs_t m = '0;
      m.st = '1; m.imem_rd = 1'b1; m.ir_wr = 1'b1; m.pc_wr = 1'b1; m.dmem_rd = 1'b1;
      m.dmem_wr = 1'b1; m.reg_wr = 1'b1; m.ill = 1'b1; m.halted = 1'b1;
      m.bus_err = 1'b1; m.cnt = '1;
      return m;
   endfunction

   function automatic obs_t base(logic [2:0] st);
      obs_t o = '0;
      o.st = st;
      o.halted = mdl_halt;
      o.bus_err = mdl_berr;
      o.cnt = CW'(retired);
      return o;
   endfunction

   function automatic void push(logic irdy, logic drdy, logic ez, obs_t e, obs_t m);
      vec_t v;
      v.ir = mdl_ir; v.irdy = irdy; v.drdy = drdy; v.ez = ez; v.exp = e; v.msk = m;
      vq.push_back(v);
   endfunction

   // Appends the expected cycle-by-cycle trace of one instruction with the given
   // fetch / data wait counts (a wait >= TO means the access never completes).
   function automatic void gen_instr(logic [31:0] word, int iw, int dw, bit ez);
      int   k = kind(word[31:26]);
      obs_t e, m, rdv, rdm;
      rdv = '0; rdm = '0;
      if (k == K_RR || k == K_IMM || k == K_LW) begin
         rdv.rd = (k == K_RR) ? word[15:11] : word[20:16];
         rdv.wb_sel = (k != K_LW);
         rdm.rd = '1; rdm.wb_sel = 1'b1;
      end
      for (int c = 0; c <= iw && c < TO; c++) begin
         e = base(3'd0); m = core_mask();
         e.imem_rd = 1'b1;
         if (c == iw) begin
            e.ir_wr = 1'b1; e.pc_wr = 1'b1; m.pc_src = '1;
         end
         push(c == iw, 1'($urandom), 1'($urandom), e, m);
      end
      if (iw >= TO) begin
         mdl_berr = 1'b1; mdl_halt = 1'b1;
         return;
      end
      mdl_ir = word;
      e = base(3'd1) | rdv; m = core_mask() | rdm;
      if (k == K_HLT) begin
         push(1'($urandom), 1'($urandom), 1'($urandom), e, m);
         mdl_halt = 1'b1;
         return;
      end
      if (k == K_J) begin
         e.pc_wr = 1'b1; e.pc_src = 2'd2; m.pc_src = '1;
         push(1'($urandom), 1'($urandom), 1'($urandom), e, m);
         retired++;
         return;
      end
      push(1'($urandom), 1'($urandom), 1'($urandom), e, m);
      e = base(3'd2) | rdv; m = core_mask() | rdm;
      m.src_a = 1'b1; m.src_b = 1'b1;
      case (k)
         K_RR: begin e.src_a = 1'b1; e.src_b = 1'b0; end
         K_IMM, K_LW, K_SW: begin e.src_a = 1'b1; e.src_b = 1'b1; end
         K_BEQZ, K_BNEZ: begin
            e.src_a = 1'b0; e.src_b = 1'b1; e.pc_src = 2'd1; m.pc_src = '1;
            e.pc_wr = (k == K_BEQZ) ? ez : !ez;
         end
         default: begin e.ill = 1'b1; m.src_a = 1'b0; m.src_b = 1'b0; end
      endcase
      push(1'($urandom), 1'($urandom), ez, e, m);
      if (k == K_BEQZ || k == K_BNEZ || k == K_ILL) begin
         retired++;
         return;
      end
      if (k == K_LW || k == K_SW) begin
         for (int c = 0; c <= dw && c < TO; c++) begin
            e = base(3'd3) | rdv; m = core_mask() | rdm;
            e.dmem_rd = (k == K_LW); e.dmem_wr = (k == K_SW);
            push(1'($urandom), c == dw, 1'($urandom), e, m);
         end
         if (dw >= TO) begin
            mdl_berr = 1'b1; mdl_halt = 1'b1;
            return;
         end
         if (k == K_SW) begin
            retired++;
            return;
         end
      end
      e = base(3'd4) | rdv; m = core_mask() | rdm;
      e.reg_wr = 1'b1;
      push(1'($urandom), 1'($urandom), 1'($urandom), e, m);
      retired++;
   endfunction

   function automatic void push_halt(int n);
      for (int i = 0; i < n; i++) begin
         push(1'($urandom), 1'($urandom), 1'($urandom), base(3'd5), core_mask());
      end
   endfunction

   // ---------------- driver / checker ----------------
   function automatic obs_t sample();
      obs_t a;
      a.st = state_o; a.imem_rd = imem_rd; a.ir_wr = ir_wr; a.pc_wr = pc_wr;
      a.dmem_rd = dmem_rd; a.dmem_wr = dmem_wr; a.reg_wr = reg_wr; a.ill = illegal_op;
      a.halted = halted; a.bus_err = bus_err; a.cnt = instr_cnt; a.pc_src = pc_src;
      a.src_a = alu_src_a; a.src_b = alu_src_b; a.wb_sel = wb_sel; a.rd = rd;
      return a;
   endfunction

   task automatic check(input string tag, input int idx, input obs_t e, input obs_t m);
      obs_t a = sample();
      tests++;
      if ($isunknown(a) || ((a ^ e) & m) != '0) begin
         failed++;
         $display("FAIL %s[%0d]: got=%h exp=%h mask=%h", tag, idx, a, e, m);
      end
   endtask

   // Applies queued records one per cycle; lat = cycles until the DUT is back in IF
   // (after having left it) or in HALT.
   task automatic run_q(input string tag, input int limit, output int lat);
      int n = (limit < vq.size()) ? limit : vq.size();
      bit left_if = 1'b0;
      lat = -1;
      for (int i = 0; i < n; i++) begin
         ir_q = vq[i].ir; imem_ready = vq[i].irdy; dmem_ready = vq[i].drdy; eqz = vq[i].ez;
         @(negedge clk);
         check(tag, i, vq[i].exp, vq[i].msk);
         @(posedge clk); #1;
         if (state_o != 3'd0) left_if = 1'b1;
         if (lat < 0 && (state_o == 3'd5 || (state_o == 3'd0 && left_if))) lat = i + 1;
      end
      vq.delete();
   endtask

   task automatic do_reset(input string tag);
      obs_t sm = '0;
      sm.imem_rd = 1'b1; sm.ir_wr = 1'b1; sm.pc_wr = 1'b1;
      sm.dmem_rd = 1'b1; sm.dmem_wr = 1'b1; sm.reg_wr = 1'b1;
      rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; eqz = 1'($urandom);
      @(negedge clk);
      check({tag, "_strobes"}, 0, '0, sm);
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, "_state"}, 1, '0, core_mask());
      @(posedge clk); #1;
      rst_n = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
      retired = 0; mdl_halt = 1'b0; mdl_berr = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int lat;
      int iw, dw;
      logic [5:0] op;
      logic [31:0] w;

      dt[0]  = '{mk(T_ADD, 5'd1, 5'd2, {5'd3, 11'd0}), 0, 0, 1'b0, 4};
      dt[1]  = '{mk(T_LW, 5'd4, 5'd7, 16'h0008), 0, 3, 1'b0, 8};
      dt[2]  = '{mk(T_BEQZ, 5'd5, 5'd0, 16'hfffe), 0, 0, 1'b1, 3};
      dt[3]  = '{mk(T_BEQZ, 5'd5, 5'd0, 16'hfffe), 0, 0, 1'b0, 3};
      dt[4]  = '{mk(T_BNEQZ, 5'd6, 5'd0, 16'h0004), 0, 0, 1'b0, 3};
      dt[5]  = '{mk(T_SW, 5'd2, 5'd8, 16'h0010), 0, 0, 1'b0, 4};
      dt[6]  = '{mk(T_J, 5'd0, 5'd0, 16'h0040), 0, 0, 1'b0, 2};
      dt[7]  = '{mk(T_ADDI, 5'd1, 5'd9, 16'h0005), 2, 0, 1'b0, 6};
      dt[8]  = '{mk(T_BAD, 5'd3, 5'd3, 16'h1234), 0, 0, 1'b0, 3};
      dt[9]  = '{mk(T_SUB, 5'd4, 5'd5, {5'd12, 11'd0}), 3, 0, 1'b0, 7};
      dt[10] = '{mk(T_SLTI, 5'd2, 5'd11, 16'h7fff), 0, 0, 1'b0, 4};
      dt[11] = '{mk(T_SW, 5'd1, 5'd1, 16'h0002), 0, 3, 1'b0, 7};
      dt[12] = '{mk(T_MUL, 5'd1, 5'd2, {5'd31, 11'd0}), 0, 0, 1'b0, 4};
      dt[13] = '{mk(T_HLT, 5'd0, 5'd0, 16'h0000), 0, 0, 1'b0, 2};
      dt[14] = '{mk(T_OR, 5'd1, 5'd2, {5'd4, 11'd0}), TO, 0, 1'b0, 4};
      dt[15] = '{mk(T_LW, 5'd9, 5'd10, 16'h0003), 0, TO, 1'b0, 7};
      ops = '{T_ADD, T_SUB, T_AND, T_OR, T_SLT, T_MUL, T_LW, T_SW,
              T_ADDI, T_SUBI, T_SLTI, T_BNEQZ, T_BEQZ, T_J, T_BAD, T_LW};

      @(posedge clk); #1;
      do_reset("rst0");

      for (int i = 0; i < 16; i++) begin
         gen_instr(dt[i].word, dt[i].iw, dt[i].dw, dt[i].ez);
         if (mdl_halt) push_halt(20);
         run_q($sformatf("dir%0d", i), 1 << 30, lat);
         tests++;
         if (lat != dt[i].lat) begin
            failed++;
            $display("FAIL dir%0d latency: got=%0d exp=%0d", i, lat, dt[i].lat);
         end
         if (mdl_halt) do_reset($sformatf("dir%0d_rst", i));
      end

      // Reset asserted while a load is waiting in MEM.
      gen_instr(mk(T_LW, 5'd2, 5'd6, 16'h0020), 0, 3, 1'b0);
      run_q("midmem", 4, lat);
      do_reset("midmem_rst");

      // Retire counter wrap: 18 jumps on a 4-bit counter.
      for (int i = 0; i < 18; i++) begin
         gen_instr(mk(T_J, 5'd0, 5'd0, 16'(i)), 0, 0, 1'b0);
         run_q("wrap", 1 << 30, lat);
      end

      for (int n = 0; n < 400; n++) begin
         op = ($urandom_range(0, 31) == 0) ? T_HLT :
              ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 15)];
         w = {op, 26'($urandom)};
         iw = ($urandom_range(0, 31) == 0) ? TO : $urandom_range(0, TO - 1);
         dw = ($urandom_range(0, 31) == 0) ? TO : $urandom_range(0, TO - 1);
         gen_instr(w, iw, dw, 1'($urandom));
         if (mdl_halt) push_halt(3);
         run_q($sformatf("rnd%0d", n), 1 << 30, lat);
         if (mdl_halt) do_reset($sformatf("rnd%0d_rst", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
